accum_mem_responder: RTL

- Word-addressed memory responder that serves the accumulator accelerator's memory interface.
- Accepts one read or write request at a time over a val/rdy handshake and returns a response after a programmable fixed latency.
- Used as the memory-side endpoint in accelerator unit/integration benches and as a simple on-chip data memory.
- Also gives the accelerator's fetch loop a deterministic backpressure source.

---
 rtl/accum_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/accum_mem_responder.sv
// ----------------------------------------------------------------------------
// accum_mem_responder
//
// Word-addressed memory responder for the accumulator accelerator's memory
// port. It accepts one read or write request at a time over a val/rdy
// handshake and returns the response a fixed, programmable number of cycles
// after the accept. It holds at most one request outstanding, so it also acts
// as a deterministic backpressure source for the accelerator's fetch loop.
//
// Parameters
//   p_nwords   number of 32-bit words stored (power of 2, 4..4096)
//   p_latency  cycles from request accept to memresp_val_o (1..15)
//
// Ports
//   clk_i            clock; all state updates on posedge
//   rst_i            synchronous active-high reset; clears storage
//   memreq_val_i     request valid
//   memreq_rdy_o     responder can accept a request (high only in IDLE)
//   memreq_type_i    0 = read, 1 = write
//   memreq_addr_i    byte address; must be word aligned
//   memreq_data_i    write data; ignored for reads
//   memresp_val_o    response valid
//   memresp_rdy_i    requester accepts the response
//   memresp_type_o   echo of the accepted request type
//   memresp_data_o   read data; 0 for writes and for errored accesses
//   err_o            sticky flag: misaligned or out-of-range access seen
// ----------------------------------------------------------------------------
module accum_mem_responder #(
    parameter int p_nwords  = 256,
    parameter int p_latency = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memreq_val_i,
    output logic        memreq_rdy_o,
    input  logic        memreq_type_i,
    input  logic [15:0] memreq_addr_i,
    input  logic [31:0] memreq_data_i,
    output logic        memresp_val_o,
    input  logic        memresp_rdy_i,
    output logic        memresp_type_o,
    output logic [31:0] memresp_data_o,
    output logic        err_o
);

    localparam int AW = $clog2(p_nwords);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        req_rdy_q;
    logic        resp_val_q;
    logic        resp_type_q;
    logic [31:0] resp_data_q;
    logic        err_q;
    logic [31:0] mem_q [p_nwords];

    // ------------------------------------------------------------------------
    // Request decode. The full 14-bit word address is compared against the
    // depth, so addresses past the end are flagged rather than aliased onto
    // the low words by the truncated index.
    // ------------------------------------------------------------------------
    logic [AW-1:0] req_idx;
    logic          req_err;
    logic          req_fire;
    logic [31:0]   resp_data_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_idx     = memreq_addr_i[AW+1:2];
        req_err     = (memreq_addr_i[1:0] != 2'b00) ||
                      ({2'b00, memreq_addr_i[15:2]} >= 16'(p_nwords));
        req_fire    = memreq_val_i && req_rdy_q;
        resp_data_d = 32'd0;
        if (!memreq_type_i && !req_err) begin
            resp_data_d = mem_q[req_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, storage and registered outputs. The read is captured into
    // resp_data_q at the accept edge, so later writes cannot disturb a
    // response that is already in flight.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_rdy_q   <= 1'b1;
            resp_val_q  <= 1'b0;
            resp_type_q <= 1'b0;
            resp_data_q <= 32'd0;
            err_q       <= 1'b0;
            // NOTE: storage is cleared by reset because the accelerator
            // benches rely on a known all-zero memory; this forces the array
            // into flops instead of a RAM macro, acceptable at this depth.
            for (int i = 0; i < p_nwords; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        resp_type_q <= memreq_type_i;
                        resp_data_q <= resp_data_d;
                        req_rdy_q   <= 1'b0;
                        if (req_err) begin
                            err_q <= 1'b1;
                        end else if (memreq_type_i) begin
                            mem_q[req_idx] <= memreq_data_i;
                        end
                        if (p_latency == 1) begin
                            state_q    <= S_RESP;
                            resp_val_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(p_latency - 1);
                        end
                    end
                end

                S_WAIT: begin
                    // cnt_q counts the remaining cycles before RESP; at 1
                    // the response becomes visible on the next cycle.
                    if (cnt_q == 4'd1) begin
                        state_q    <= S_RESP;
                        resp_val_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                S_RESP: begin
                    if (memresp_rdy_i) begin
                        state_q    <= S_IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    resp_val_q <= 1'b0;
                    req_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign memreq_rdy_o   = req_rdy_q;
    assign memresp_val_o  = resp_val_q;
    assign memresp_type_o = resp_type_q;
    assign memresp_data_o = resp_data_q;
    assign err_o          = err_q;

endmodule
